// File: rtl/passcode_frame_encoder_pkg.sv
// Shared definitions for the passcode frame encoder.
// FSM encodings and default geometry.
package passcode_frame_encoder_pkg;

  localparam int N_DIGITS_DEF  = 4;
  localparam int DIGIT_W_DEF   = 4;
  localparam int DIGIT_MAX_DEF = 9;

  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_HOLD    = 1'b1;

endpackage

// File: rtl/passcode_frame_encoder_if.sv
// Digit-in / frame-out handshake bundle for the passcode encoder.
// PASSCODE_CHECKSUM_EN adds the frame_chk signal.
interface passcode_frame_encoder_if
  import passcode_frame_encoder_pkg::*;
#(
  parameter int N_DIGITS = N_DIGITS_DEF,
  parameter int DIGIT_W  = DIGIT_W_DEF
);
  localparam int CODE_W = DIGIT_W + 1;
  localparam int CNT_W  = $clog2(N_DIGITS + 1);

  logic                       in_valid;
  logic                       in_ready;
  logic [DIGIT_W-1:0]         in_digit;
  logic                       frame_valid;
  logic                       frame_ready;
  logic [N_DIGITS*CODE_W-1:0] frame_data;
  logic                       frame_err;
  logic [CNT_W-1:0]           digit_cnt;
`ifdef PASSCODE_CHECKSUM_EN
  logic [CODE_W-1:0]          frame_chk;
`endif

  modport master (
    output in_valid, in_digit, frame_ready,
    input  in_ready, frame_valid, frame_data,
    input  frame_err, digit_cnt
`ifdef PASSCODE_CHECKSUM_EN
    , input frame_chk
`endif
  );

  modport slave (
    input  in_valid, in_digit, frame_ready,
    output in_ready, frame_valid, frame_data,
    output frame_err, digit_cnt
`ifdef PASSCODE_CHECKSUM_EN
    , output frame_chk
`endif
  );

endinterface

// File: rtl/passcode_frame_encoder_enc.sv
// Digit to even-parity code, plus out-of-range flag.
module digit_parity_enc
  import passcode_frame_encoder_pkg::*;
#(
  parameter int DIGIT_W   = DIGIT_W_DEF,
  parameter int DIGIT_MAX = DIGIT_MAX_DEF
) (
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W:0]   code,
  output logic               bad
);

  assign code = {^digit, digit};
  assign bad  = digit > DIGIT_W'(DIGIT_MAX);

endmodule

// File: rtl/passcode_frame_encoder.sv
// Collects N_DIGITS parity-coded digits into one frame.
// PASSCODE_CHECKSUM_EN adds a running code checksum (frame_chk).
module passcode_frame_encoder
  import passcode_frame_encoder_pkg::*;
#(
  parameter int N_DIGITS  = N_DIGITS_DEF,
  parameter int DIGIT_W   = DIGIT_W_DEF,
  parameter int DIGIT_MAX = DIGIT_MAX_DEF
) (
  input logic                      clk,
  input logic                      rst_n,
  input logic                      clear,
  passcode_frame_encoder_if.slave  bus
);

  localparam int CODE_W = DIGIT_W + 1;
  localparam int CNT_W  = $clog2(N_DIGITS + 1);
  localparam int FW     = N_DIGITS * CODE_W;

  logic [0:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [FW-1:0]     data;
  logic              err;
  logic [CODE_W-1:0] code;
  logic              bad;
`ifdef PASSCODE_CHECKSUM_EN
  logic [CODE_W-1:0] chk;
`endif

  digit_parity_enc #(
    .DIGIT_W   (DIGIT_W),
    .DIGIT_MAX (DIGIT_MAX)
  ) u_enc (
    .digit (bus.in_digit),
    .code  (code),
    .bad   (bad)
  );

  // clear takes the same path as reset so no handshake can slip past it
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state <= ST_COLLECT;
      cnt   <= '0;
      data  <= '0;
      err   <= 1'b0;
`ifdef PASSCODE_CHECKSUM_EN
      chk   <= '0;
`endif
    end else begin
      unique case (1'b1)
        (state == ST_COLLECT): begin
          if (bus.in_valid) begin
            for (int i = 0; i < N_DIGITS; i++) begin
              if (cnt == CNT_W'(i))
                data[i*CODE_W +: CODE_W] <= code;
            end
            cnt <= cnt + 1'b1;
            err <= err | bad;
`ifdef PASSCODE_CHECKSUM_EN
            chk <= chk + code;
`endif
            if (cnt == CNT_W'(N_DIGITS - 1))
              state <= ST_HOLD;
          end
        end
        (state == ST_HOLD): begin
          if (bus.frame_ready) begin
            state <= ST_COLLECT;
            cnt   <= '0;
            data  <= '0;
            err   <= 1'b0;
`ifdef PASSCODE_CHECKSUM_EN
            chk   <= '0;
`endif
          end
        end
        default: state <= ST_COLLECT;
      endcase
    end
  end

  assign bus.in_ready    = (state == ST_COLLECT);
  assign bus.frame_valid = (state == ST_HOLD);
  assign bus.frame_data  = data;
  assign bus.frame_err   = err;
  assign bus.digit_cnt   = cnt;
`ifdef PASSCODE_CHECKSUM_EN
  assign bus.frame_chk   = chk;
`endif

endmodule

// File: tb/tb_passcode_frame_encoder.sv
// Directed bench: 4-digit and 1-digit encoder instances.
module tb_passcode_frame_encoder;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  passcode_frame_encoder_if #(.N_DIGITS(4), .DIGIT_W(4)) b4 ();
  passcode_frame_encoder_if #(.N_DIGITS(1), .DIGIT_W(4)) b1 ();

  passcode_frame_encoder #(.N_DIGITS(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (b4)
  );

  passcode_frame_encoder #(.N_DIGITS(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (b1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send4(input logic [3:0] d);
    b4.in_valid = 1'b1;
    b4.in_digit = d;
    step();
    b4.in_valid = 1'b0;
  endtask

  task automatic idle_checks(input string tag);
    check({tag, "_valid"}, 32'(b4.frame_valid), 32'd0);
    check({tag, "_ready"}, 32'(b4.in_ready), 32'd1);
    check({tag, "_cnt"}, 32'(b4.digit_cnt), 32'd0);
    check({tag, "_data"}, 32'(b4.frame_data), 32'd0);
    check({tag, "_err"}, 32'(b4.frame_err), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    b4.in_valid = 1'b0;
    b4.in_digit = '0;
    b4.frame_ready = 1'b1;
    b1.in_valid = 1'b0;
    b1.in_digit = '0;
    b1.frame_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    idle_checks("rst");
    check("rst1_valid", 32'(b1.frame_valid), 32'd0);

    // 1: 1,2,3,4 -> codes 11,12,03,14
    send4(4'd1);
    send4(4'd2);
    send4(4'd3);
    check("t1_cnt3", 32'(b4.digit_cnt), 32'd3);
    check("t1_pre_valid", 32'(b4.frame_valid), 32'd0);
    send4(4'd4);
    check("t1_valid", 32'(b4.frame_valid), 32'd1);
    check("t1_ready", 32'(b4.in_ready), 32'd0);
    check("t1_cnt", 32'(b4.digit_cnt), 32'd4);
    check("t1_data", 32'(b4.frame_data), 32'h000A0E51);
    check("t1_err", 32'(b4.frame_err), 32'd0);
`ifdef PASSCODE_CHECKSUM_EN
    check("t1_chk", 32'(b4.frame_chk), 32'h1A);
`endif
    step();
    idle_checks("t1_done");

    // 2: backpressure with extra in_valid
    b4.frame_ready = 1'b0;
    send4(4'd7);
    send4(4'd0);
    send4(4'd0);
    send4(4'd0);
    b4.in_valid = 1'b1;
    b4.in_digit = 4'd5;
    for (int i = 0; i < 10; i++) begin
      check("t2_valid", 32'(b4.frame_valid), 32'd1);
      check("t2_ready", 32'(b4.in_ready), 32'd0);
      step();
    end
    b4.in_valid = 1'b0;
    check("t2_slot0", 32'(b4.frame_data[4:0]), 32'h17);
    check("t2_data", 32'(b4.frame_data), 32'h00000017);
    check("t2_cnt", 32'(b4.digit_cnt), 32'd4);
    b4.frame_ready = 1'b1;
    step();
    idle_checks("t2_done");

    // 3: out-of-range digit, then a clean frame
    send4(4'd5);
    send4(4'd12);
    send4(4'd0);
    send4(4'd0);
    check("t3_err", 32'(b4.frame_err), 32'd1);
    check("t3_data", 32'(b4.frame_data), 32'h00000185);
    step();
    for (int i = 0; i < 4; i++) send4(4'd1);
    check("t3b_valid", 32'(b4.frame_valid), 32'd1);
    check("t3b_err", 32'(b4.frame_err), 32'd0);
    check("t3b_data", 32'(b4.frame_data), 32'h0008C631);
    step();

    // 4: clear with in_valid discards the digit
    send4(4'd3);
    send4(4'd3);
    check("t4_cnt2", 32'(b4.digit_cnt), 32'd2);
    clear = 1'b1;
    b4.in_valid = 1'b1;
    b4.in_digit = 4'd9;
    step();
    clear = 1'b0;
    b4.in_valid = 1'b0;
    idle_checks("t4_clr");
    send4(4'd9);
    send4(4'd8);
    send4(4'd0);
    send4(4'd2);
    check("t4_valid", 32'(b4.frame_valid), 32'd1);
    check("t4_data", 32'(b4.frame_data), 32'h00090309);
    check("t4_err", 32'(b4.frame_err), 32'd0);
`ifdef PASSCODE_CHECKSUM_EN
    check("t4_chk", 32'(b4.frame_chk), 32'h13);
`endif
    step();

    // clear while holding a frame drops it
    b4.frame_ready = 1'b0;
    for (int i = 0; i < 4; i++) send4(4'd6);
    check("tc_valid", 32'(b4.frame_valid), 32'd1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    idle_checks("tc_drop");

    // 5: reset pulse in HOLD
    send4(4'd1);
    send4(4'd2);
    send4(4'd3);
    send4(4'd4);
    check("t5_valid", 32'(b4.frame_valid), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    idle_checks("t5_rst");
    b4.frame_ready = 1'b1;

    // 6: single-digit frames, one every two cycles
    b1.in_valid = 1'b1;
    for (int d = 0; d <= 10; d++) begin
      logic [3:0] dv;
      dv = 4'(d);
      b1.in_digit = dv;
      check("t6_pre", 32'(b1.frame_valid), 32'd0);
      step();
      check("t6_valid", 32'(b1.frame_valid), 32'd1);
      check("t6_data", 32'(b1.frame_data), 32'({^dv, dv}));
      check("t6_err", 32'(b1.frame_err), 32'(d > 9));
      check("t6_cnt", 32'(b1.digit_cnt), 32'd1);
      step();
    end
    b1.in_valid = 1'b0;
    check("t6_end", 32'(b1.frame_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
